// File: rtl/reg_write_ctrl.sv
// Write-port controller for the 16x16 register bank: arbitrates two writeback
// requesters onto one write port, sequences W as setup/strobe/hold, clears the
// bank after reset and flags read-after-write hazards on the two read ports.
module reg_write_ctrl #(
  parameter int unsigned TAM = 16,
  parameter bit          RR  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic [3:0]     a_rd,
  input  logic [TAM-1:0] a_data,
  input  logic           b_valid,
  output logic           b_ready,
  input  logic [3:0]     b_rd,
  input  logic [TAM-1:0] b_data,
  output logic [3:0]     rf_RD,
  output logic [TAM-1:0] rf_reg_in,
  output logic           rf_W,
  output logic           rf_rst,
  input  logic [3:0]     rd_addr1,
  input  logic [3:0]     rd_addr2,
  output logic           hazard1,
  output logic           hazard2,
  output logic           busy
);

  typedef enum logic [2:0] {
    S_INIT_SETUP,
    S_INIT_STROBE,
    S_INIT_HOLD,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t         state_q;
  logic           last_b_q;
  logic [3:0]     rd_q;
  logic [TAM-1:0] data_q;
  logic           w_q;
  logic           clr_q;
  logic           busy_q;

  logic           pick_a;
  logic           a_go;
  logic           b_go;

  // Arbitration: A wins a tie under fixed priority, or under round-robin when B was granted last
  always_comb begin
    pick_a  = a_valid & (~b_valid | ~RR | last_b_q);
    a_ready = (state_q == S_IDLE) & a_valid & pick_a;
    b_ready = (state_q == S_IDLE) & b_valid & ~pick_a;
    a_go    = a_valid & a_ready;
    b_go    = b_valid & b_ready;
  end

  // Sequencer: one state per cycle; W registered so it is high exactly in a strobe cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_INIT_SETUP;
      w_q      <= 1'b0;
      clr_q    <= 1'b1;
      rd_q     <= '0;
      data_q   <= '0;
      last_b_q <= 1'b1;
      busy_q   <= 1'b1;
    end else begin
      w_q <= 1'b0;
      case (state_q)
        S_INIT_SETUP: begin
          state_q <= S_INIT_STROBE;
          w_q     <= 1'b1;
        end
        S_INIT_STROBE: state_q <= S_INIT_HOLD;
        S_INIT_HOLD: begin
          state_q <= S_IDLE;
          clr_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        S_IDLE: begin
          if (a_go || b_go) begin
            state_q  <= S_SETUP;
            busy_q   <= 1'b1;
            rd_q     <= a_go ? a_rd : b_rd;
            data_q   <= a_go ? a_data : b_data;
            last_b_q <= b_go;
          end
        end
        S_SETUP: begin
          state_q <= S_STROBE;
          w_q     <= 1'b1;
        end
        S_STROBE: state_q <= S_HOLD;
        S_HOLD: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_INIT_SETUP;
          clr_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Hazards: whole bank stale while clearing, only the target register while writing
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    case (state_q)
      S_INIT_SETUP, S_INIT_STROBE, S_INIT_HOLD: begin
        hazard1 = 1'b1;
        hazard2 = 1'b1;
      end
      S_SETUP, S_STROBE, S_HOLD: begin
        hazard1 = (rd_addr1 == rd_q);
        hazard2 = (rd_addr2 == rd_q);
      end
      default: begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
      end
    endcase
  end

  assign rf_RD     = rd_q;
  assign rf_reg_in = data_q;
  assign rf_W      = w_q;
  assign rf_rst    = clr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Bench for reg_write_ctrl: a round-robin and a fixed-priority instance share
// random stimulus; a cycle-count reference model predicts handshakes, W, hazards
// and bank contents, while a monitor checks each write pulse against a scoreboard.
module tb_reg_write_ctrl;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid, b_valid;
  logic [3:0]  a_rd, b_rd, rd_addr1, rd_addr2;
  logic [15:0] a_data, b_data;

  logic        a_ready_w [2];
  logic        b_ready_w [2];
  logic        rf_W_w    [2];
  logic        rf_rst_w  [2];
  logic        hz1_w     [2];
  logic        hz2_w     [2];
  logic        busy_w    [2];
  logic [3:0]  rf_RD_w   [2];
  logic [15:0] rf_reg_in_w [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_write_ctrl #(.TAM(16), .RR(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready_w[0]), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready_w[0]), .b_rd(b_rd), .b_data(b_data),
    .rf_RD(rf_RD_w[0]), .rf_reg_in(rf_reg_in_w[0]), .rf_W(rf_W_w[0]), .rf_rst(rf_rst_w[0]),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .hazard1(hz1_w[0]), .hazard2(hz2_w[0]), .busy(busy_w[0])
  );

  reg_write_ctrl #(.TAM(16), .RR(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready_w[1]), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready_w[1]), .b_rd(b_rd), .b_data(b_data),
    .rf_RD(rf_RD_w[1]), .rf_reg_in(rf_reg_in_w[1]), .rf_W(rf_W_w[1]), .rf_rst(rf_rst_w[1]),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .hazard1(hz1_w[1]), .hazard2(hz2_w[1]), .busy(busy_w[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Bank behaviour: latches on rising W, clears everything when its rst is high
  logic [15:0] bank [2][16];
  always @(posedge rf_W_w[0]) begin
    if (rf_rst_w[0]) for (int i = 0; i < 16; i++) bank[0][i] = 16'h0;
    else bank[0][rf_RD_w[0]] = rf_reg_in_w[0];
  end
  always @(posedge rf_W_w[1]) begin
    if (rf_rst_w[1]) for (int i = 0; i < 16; i++) bank[1][i] = 16'h0;
    else bank[1][rf_RD_w[1]] = rf_reg_in_w[1];
  end

  // Reference model: each job (clear or write) occupies 3 busy cycles, W in the middle one
  int          bl      [2];
  bit          init_m  [2];
  bit          last_b  [2];
  logic [3:0]  exp_rd  [2];
  logic [15:0] exp_data[2];
  logic [15:0] ref_mem [2][16];
  wr_t         sbq     [2][$];
  bit          started = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit ga, gb, rr, hz1e, hz2e;
      rr = (k == 0);
      ga = 1'b0;
      gb = 1'b0;
      if (started && bl[k] == 0) begin
        if (a_valid && b_valid) begin
          if (rr && !last_b[k]) gb = 1'b1;
          else ga = 1'b1;
        end else if (a_valid) ga = 1'b1;
        else if (b_valid) gb = 1'b1;
      end
      hz1e = (bl[k] == 0) ? 1'b0 : (init_m[k] ? 1'b1 : (rd_addr1 == exp_rd[k]));
      hz2e = (bl[k] == 0) ? 1'b0 : (init_m[k] ? 1'b1 : (rd_addr2 == exp_rd[k]));
      if (started) begin
        chk("a_ready", k, 32'(a_ready_w[k]), 32'(ga));
        chk("b_ready", k, 32'(b_ready_w[k]), 32'(gb));
        chk("rf_W", k, 32'(rf_W_w[k]), 32'(bl[k] == 2));
        chk("rf_rst", k, 32'(rf_rst_w[k]), 32'(init_m[k]));
        chk("busy", k, 32'(busy_w[k]), 32'(bl[k] != 0));
        chk("hazard1", k, 32'(hz1_w[k]), 32'(hz1e));
        chk("hazard2", k, 32'(hz2_w[k]), 32'(hz2e));
        chk("rf_RD", k, 32'(rf_RD_w[k]), 32'(exp_rd[k]));
        chk("rf_reg_in", k, 32'(rf_reg_in_w[k]), 32'(exp_data[k]));
      end
      if (!rst) begin
        init_m[k]   = 1'b1;
        bl[k]       = 3;
        exp_rd[k]   = 4'h0;
        exp_data[k] = 16'h0;
        last_b[k]   = 1'b1;
      end else if (bl[k] != 0) begin
        if (bl[k] == 3) begin
          if (init_m[k]) for (int i = 0; i < 16; i++) ref_mem[k][i] = 16'h0;
          else begin
            ref_mem[k][exp_rd[k]] = exp_data[k];
            sbq[k].push_back('{rd: exp_rd[k], data: exp_data[k]});
          end
        end
        bl[k]--;
        if (bl[k] == 0) init_m[k] = 1'b0;
      end else if (ga || gb) begin
        exp_rd[k]   = ga ? a_rd : b_rd;
        exp_data[k] = ga ? a_data : b_data;
        last_b[k]   = gb;
        bl[k]       = 3;
      end
    end
    if (!rst) started = 1'b1;
  end

  // Monitor: every data write pulse must match the next scoreboard entry and be glitch-free
  bit          mon_on = 1'b0;
  bit          mon_arm = 1'b0;
  bit          rst_last = 1'b0;
  logic        prev_w  [2];
  logic [3:0]  prev_rd [2];
  logic [15:0] prev_dat[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      wr_t e;
      if (mon_on) begin
        if (rf_W_w[k] && prev_w[k]) chk("w_double", k, 32'(1), 32'(0));
        if (rf_W_w[k] && !prev_w[k]) begin
          chk("setup_rd", k, 32'(rf_RD_w[k]), 32'(prev_rd[k]));
          chk("setup_data", k, 32'(rf_reg_in_w[k]), 32'(prev_dat[k]));
        end
        if (!rf_W_w[k] && prev_w[k] && rst_last) begin
          chk("hold_rd", k, 32'(rf_RD_w[k]), 32'(prev_rd[k]));
          chk("hold_data", k, 32'(rf_reg_in_w[k]), 32'(prev_dat[k]));
        end
        if (rf_W_w[k] && !rf_rst_w[k]) begin
          if (sbq[k].size() == 0) chk("unexpected_write", k, 32'(1), 32'(0));
          else begin
            e = sbq[k].pop_front();
            chk("wr_rd", k, 32'(rf_RD_w[k]), 32'(e.rd));
            chk("wr_data", k, 32'(rf_reg_in_w[k]), 32'(e.data));
          end
        end
      end
      prev_w[k]   = rf_W_w[k];
      prev_rd[k]  = rf_RD_w[k];
      prev_dat[k] = rf_reg_in_w[k];
    end
    rst_last = rst;
    if (mon_arm) mon_on = 1'b1;
    if (!rst) mon_arm = 1'b1;
  end

  function automatic logic [3:0] pick_rd();
    return ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
  endfunction

  // Stimulus: reset, then random phases and phases with both requesters held valid
  initial begin
    a_valid  = 1'b0;
    b_valid  = 1'b0;
    a_rd     = 4'h0;
    b_rd     = 4'h0;
    a_data   = 16'h0;
    b_data   = 16'h0;
    rd_addr1 = 4'h0;
    rd_addr2 = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    for (int c = 0; c < 3000; c++) begin
      bit both_mode;
      both_mode = ((c / 200) % 3) == 1;
      @(posedge clk);
      #1;
      a_rd     = pick_rd();
      b_rd     = pick_rd();
      a_data   = 16'($urandom);
      b_data   = 16'($urandom);
      rd_addr1 = 4'($urandom_range(0, 3));
      rd_addr2 = pick_rd();
      if (both_mode) begin
        a_valid = 1'b1;
        b_valid = 1'b1;
        rst     = 1'b1;
      end else begin
        a_valid = ($urandom_range(0, 2) != 0);
        b_valid = ($urandom_range(0, 2) != 0);
        rst     = ($urandom_range(0, 59) != 0);
      end
    end
    @(posedge clk);
    #1;
    rst     = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("sb_empty", k, 32'(sbq[k].size()), 32'(0));
      for (int i = 0; i < 16; i++) chk("bank", k * 16 + i, 32'(bank[k][i]), 32'(ref_mem[k][i]));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
